// File: rtl/zion_processor_component_lib_reg_file_if.sv
// Register-file port bundle: two read channels, one writeback port and the
// pending-writer scoreboard controls. The regfile is the slave side.
interface zion_processor_component_lib_reg_file_if #(
  parameter int unsigned XLEN = 32
);
  logic [4:0]      rd0_rs;
  logic [XLEN-1:0] rd0_dat;
  logic            rd0_rdy;
  logic [4:0]      rd1_rs;
  logic [XLEN-1:0] rd1_dat;
  logic            rd1_rdy;
  logic            wr_en;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_dat;
  logic            sb_set_en;
  logic [4:0]      sb_set_rd;
  logic            sb_flush;
  logic [31:0]     busy;

  modport master (
    output rd0_rs, rd1_rs, wr_en, wr_rd, wr_dat, sb_set_en, sb_set_rd, sb_flush,
    input  rd0_dat, rd0_rdy, rd1_dat, rd1_rdy, busy
  );

  modport slave (
    input  rd0_rs, rd1_rs, wr_en, wr_rd, wr_dat, sb_set_en, sb_set_rd, sb_flush,
    output rd0_dat, rd0_rdy, rd1_dat, rd1_rdy, busy
  );
endinterface

// File: rtl/zion_processor_component_lib_reg_file.sv
// Integer register file (x1..x31) with two combinational read channels, one
// writeback port and a pending-writer scoreboard used by issue to stall.
module zion_processor_component_lib_reg_file #(
  parameter int unsigned RV64   = 0,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  zion_processor_component_lib_reg_file_if.slave rf
);
  localparam int unsigned XLEN = 32 * (1 + RV64);

  logic [XLEN-1:0] regs_q [31:1];
  logic [XLEN-1:0] regs_d [31:1];
  logic [31:1]     pending_q;
  logic [31:1]     pending_d;
  logic [31:0]     busy;
  logic [XLEN-1:0] rd0_stored;
  logic [XLEN-1:0] rd1_stored;
  logic            byp0;
  logic            byp1;

  assign busy    = {pending_q, 1'b0};
  assign rf.busy = busy;

  // Next-state for data storage and scoreboard bits
  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = (rf.wr_en && (rf.wr_rd == 5'(i))) ? rf.wr_dat : regs_q[i];
      // Flush beats set, and set beats clear so a freshly issued writer is not lost
      if (rf.sb_flush) begin
        pending_d[i] = 1'b0;
      end else if (rf.sb_set_en && (rf.sb_set_rd == 5'(i))) begin
        pending_d[i] = 1'b1;
      end else if (rf.wr_en && (rf.wr_rd == 5'(i))) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pending_q <= pending_d;
    end
  end

  // Read muxes with optional same-cycle writeback forwarding
  always_comb begin
    rd0_stored = '0;
    rd1_stored = '0;
    for (int i = 1; i < 32; i++) begin
      rd0_stored = (rf.rd0_rs == 5'(i)) ? regs_q[i] : rd0_stored;
      rd1_stored = (rf.rd1_rs == 5'(i)) ? regs_q[i] : rd1_stored;
    end
    byp0 = BYPASS && rf.wr_en && (rf.wr_rd == rf.rd0_rs) && (rf.rd0_rs != 5'd0);
    byp1 = BYPASS && rf.wr_en && (rf.wr_rd == rf.rd1_rs) && (rf.rd1_rs != 5'd0);
    rf.rd0_dat = byp0 ? rf.wr_dat : rd0_stored;
    rf.rd1_dat = byp1 ? rf.wr_dat : rd1_stored;
    rf.rd0_rdy = (rf.rd0_rs == 5'd0) || !busy[rf.rd0_rs] || byp0;
    rf.rd1_rdy = (rf.rd1_rs == 5'd0) || !busy[rf.rd1_rs] || byp1;
  end
endmodule

// File: doc/zion_processor_component_lib_reg_file.md
# zion_processor_component_lib_reg_file

Integer register file with a pending-write scoreboard. It is the regfile-side endpoint of the register-file read channel (rs in, dat out). It serves two read channels and one writeback port, and tracks which architectural registers have an in-flight writer. It sits between the decode/issue stage (read channels, scoreboard set) and the writeback stage (write port, scoreboard clear).

## Interface
- RV64, 0, data width is 32*(1+RV64) bits (32 when 0, 64 when 1)
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = no forwarding
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- rd0_rs  input  5  read channel 0 register index
- rd0_dat  output  XLEN  read channel 0 data
- rd0_rdy  output  1  register at rd0_rs has no pending writer (data valid to consume)
- rd1_rs  input  5  read channel 1 register index
- rd1_dat  output  XLEN  read channel 1 data
- rd1_rdy  output  1  as rd0_rdy for channel 1
- wr_en  input  1  writeback valid
- wr_rd  input  5  writeback destination index
- wr_dat  input  XLEN  writeback data
- sb_set_en  input  1  issue of an instruction that will write sb_set_rd
- sb_set_rd  input  5  destination to mark pending
- sb_flush  input  1  clear all pending bits (pipeline flush)
- busy  output  32  pending bit vector, bit i = register i pending (bit 0 always 0)

## Operation
- Storage: 31 registers x1..x31 of XLEN bits; x0 not stored, reads as 0, writes to x0 ignored.
- Read: rdN_dat combinational from rdN_rs. rdN_rs=0 gives 0. If BYPASS=1, wr_en=1 and wr_rd==rdN_rs!=0, then rdN_dat=wr_dat; otherwise it is the stored value.
- Write: on clk rise with wr_en=1 and wr_rd!=0, reg[wr_rd] <= wr_dat.
- Scoreboard: pending[31:1] flops; pending[0] tied 0.
  - Clear: wr_en=1 clears pending[wr_rd].
  - Set: sb_set_en=1 sets pending[sb_set_rd] (ignored when rd=0).
  - Same index set and cleared in one cycle: set wins (a new writer is issued after the old one retires).
  - sb_flush=1: all pending bits clear next cycle, overriding the same-cycle set. A same-cycle write still updates data.
- Ready: rdN_rdy = (rdN_rs==0) | ~pending[rdN_rs] | (BYPASS & wr_en & wr_rd==rdN_rs).
- Both read channels are independent; same index on both returns identical data/rdy.
- busy = {pending[31:1], 1'b0}.

## Timing
- Reset (rst_n low, async): all registers 0, all pending 0. Hence rdN_dat=0, rdN_rdy=1, busy=0 during and after reset.
- Read latency 0 cycles, combinational from rdN_rs, wr_* (bypass) and state.
- Write latency 1 cycle: with BYPASS=0, the value is visible on the read port the cycle after wr_en. With BYPASS=1, it is visible in the same cycle.
- Scoreboard set takes effect the cycle after sb_set_en. An index set in cycle N reads rdy=0 from cycle N+1 until the cycle of its writeback (BYPASS=1) or the cycle after (BYPASS=0).
- No handshake stall inside the block; the consumer stalls on rdy=0.
- Reset asserted mid-operation discards all data and pending state immediately. No write completes in a cycle where rst_n is low.

## Test plan
- Reset: hold rst_n=0 with random inputs, release. Read all 32 indices -> dat=0, rdy=1, busy=0.
- x0: wr_en=1, wr_rd=0, wr_dat=32'hDEADBEEF. Next cycle rd0_rs=0 -> rd0_dat=0. Also sb_set_rd=0 -> busy stays 0.
- Write/read and bypass: write x5=32'h12345678 with rd1_rs=5 in the same cycle.
  - BYPASS=1 -> rd1_dat=32'h12345678 in the same cycle.
  - BYPASS=0 -> old value (0) in the same cycle, 32'h12345678 next cycle.
- Scoreboard: sb_set x7 in cycle 0 -> busy=32'h80 and rd0_rdy=0 for rs=7 from cycle 1. Writeback x7 in cycle 3 -> rdy=1 in cycle 3 (BYPASS=1), busy=0 in cycle 4.
- Simultaneous set/clear: x9 pending, then wr_en x9 plus sb_set x9 in the same cycle -> data updated and busy[9] remains 1 next cycle.
- Flush and RV64: set x1, x2, x31, then sb_flush plus sb_set x4 -> busy=0. With RV64=1, write x3=64'hFFFF_0000_1234_5678 -> full 64-bit readback.
